// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester handshakes plus register-file write and forwarding outputs
interface regfile_write_arbiter_if #(parameter int CNT_W = 16);
    logic stall;
    logic req0_valid;
    logic [4:0] req0_addr;
    logic [31:0] req0_data;
    logic req0_ready;
    logic req1_valid;
    logic [4:0] req1_addr;
    logic [31:0] req1_data;
    logic req1_ready;
    logic [31:0] writeEnable;
    logic [31:0] writeData;
    logic fwd_valid;
    logic [4:0] fwd_addr;
    logic [31:0] fwd_data;
    logic [CNT_W-1:0] writeCount;
    modport master(
        output stall, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        input req0_ready, req1_ready, writeEnable, writeData, fwd_valid, fwd_addr, fwd_data, writeCount
    );
    modport slave(
        input stall, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready, writeEnable, writeData, fwd_valid, fwd_addr, fwd_data, writeCount
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbitration of two writeback ports into a one-cycle register-file write stage
module regfile_write_arbiter #(
    parameter bit ZERO_PROTECT = 1'b1,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    regfile_write_arbiter_if.slave bus
);
    logic prio, wrValid, sel1, grantOk, xfer, protect, fwdValid;
    logic [4:0] wrAddr, nextAddr;
    logic [31:0] wrData, nextData;
    logic [CNT_W-1:0] count;
    // With both or neither requester valid the pointer decides, so an idle requester never steals a turn
    always_comb begin
        grantOk = rst && !bus.stall;
        sel1 = (bus.req0_valid == bus.req1_valid) ? prio : bus.req1_valid;
        xfer = grantOk && (sel1 ? bus.req1_valid : bus.req0_valid);
        nextAddr = sel1 ? bus.req1_addr : bus.req0_addr;
        nextData = sel1 ? bus.req1_data : bus.req0_data;
        protect = ZERO_PROTECT && wrAddr == 5'd0;
        fwdValid = wrValid && !protect;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio <= 1'b0;
            wrValid <= 1'b0;
            wrAddr <= 5'd0;
            wrData <= 32'd0;
            count <= '0;
        end else begin
            wrValid <= xfer;
            if (xfer) begin
                prio <= !sel1;
                wrAddr <= nextAddr;
                wrData <= nextData;
            end
            if (xfer && !(ZERO_PROTECT && nextAddr == 5'd0))
                count <= count + CNT_W'(1);
        end
    end
    assign bus.req0_ready = grantOk && !sel1;
    assign bus.req1_ready = grantOk && sel1;
    assign bus.writeEnable = ~(32'(fwdValid) << wrAddr);
    assign bus.writeData = wrData;
    assign bus.fwd_valid = fwdValid;
    assign bus.fwd_addr = wrAddr;
    assign bus.fwd_data = wrData;
    assign bus.writeCount = count;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: table-driven vectors with a scoreboard queue, plus reset and counter-wrap sequences
module tb_regfile_write_arbiter;
    localparam int CNT_W = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.CNT_W(CNT_W)) bus();
    regfile_write_arbiter #(.ZERO_PROTECT(1'b1), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic v0; logic [4:0] a0; logic [31:0] d0;
        logic v1; logic [4:0] a1; logic [31:0] d1;
        logic st; int g; logic [31:0] we; logic [CNT_W-1:0] cnt;
    } vec_t;
    typedef struct {
        logic [31:0] we; logic [31:0] data; logic fv; logic [4:0] fa; logic [CNT_W-1:0] cnt;
    } exp_t;

    vec_t vecs[15];
    exp_t sbq[$];
    int errors = 0;
    int checks = 0;
    logic [31:0] lastData = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        bus.stall = st;
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    endtask

    // g: 0 no grant, 1 req0, 2 req1, 3 idle (only mutual exclusion required)
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        logic xfer;
        @(negedge clk);
        drive(v.st, v.v0, v.a0, v.d0, v.v1, v.a1, v.d1);
        #1;
        if (v.g == 3)
            check($sformatf("v%0d ready_excl", idx), 64'(bus.req0_ready & bus.req1_ready), 64'd0);
        else begin
            check($sformatf("v%0d req0_ready", idx), 64'(bus.req0_ready), 64'(v.g == 1));
            check($sformatf("v%0d req1_ready", idx), 64'(bus.req1_ready), 64'(v.g == 2));
        end
        xfer = (v.g == 1 && v.v0) || (v.g == 2 && v.v1);
        if (xfer) lastData = (v.g == 1) ? v.d0 : v.d1;
        e.we = v.we;
        e.data = lastData;
        e.fa = (v.g == 1) ? v.a0 : v.a1;
        e.fv = xfer && e.fa != 5'd0;
        e.cnt = v.cnt;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check($sformatf("v%0d writeEnable", idx), 64'(bus.writeEnable), 64'(e.we));
        check($sformatf("v%0d writeData", idx), 64'(bus.writeData), 64'(e.data));
        check($sformatf("v%0d fwd_valid", idx), 64'(bus.fwd_valid), 64'(e.fv));
        check($sformatf("v%0d writeCount", idx), 64'(bus.writeCount), 64'(e.cnt));
        if (e.fv) begin
            check($sformatf("v%0d fwd_addr", idx), 64'(bus.fwd_addr), 64'(e.fa));
            check($sformatf("v%0d fwd_data", idx), 64'(bus.fwd_data), 64'(e.data));
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 1, 32'hFFFFFFDF, 16'd1};
        vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0, 2, 32'hFFFFFFFF, 16'd1};
        vecs[2]  = '{1'b1, 5'd1, 32'hA1A1A1A1, 1'b1, 5'd2, 32'hB2B2B2B2, 1'b0, 1, 32'hFFFFFFFD, 16'd2};
        vecs[3]  = '{1'b1, 5'd1, 32'hA1A1A1A1, 1'b1, 5'd2, 32'hB2B2B2B2, 1'b0, 2, 32'hFFFFFFFB, 16'd3};
        vecs[4]  = '{1'b1, 5'd1, 32'hA1A1A1A1, 1'b1, 5'd2, 32'hB2B2B2B2, 1'b0, 1, 32'hFFFFFFFD, 16'd4};
        vecs[5]  = '{1'b1, 5'd1, 32'hA1A1A1A1, 1'b1, 5'd2, 32'hB2B2B2B2, 1'b0, 2, 32'hFFFFFFFB, 16'd5};
        vecs[6]  = '{1'b1, 5'd1, 32'hA1A1A1A1, 1'b1, 5'd2, 32'hB2B2B2B2, 1'b1, 0, 32'hFFFFFFFF, 16'd5};
        vecs[7]  = '{1'b1, 5'd1, 32'hA1A1A1A1, 1'b1, 5'd2, 32'hB2B2B2B2, 1'b1, 0, 32'hFFFFFFFF, 16'd5};
        vecs[8]  = '{1'b1, 5'd1, 32'hA1A1A1A1, 1'b1, 5'd2, 32'hB2B2B2B2, 1'b1, 0, 32'hFFFFFFFF, 16'd5};
        vecs[9]  = '{1'b1, 5'd1, 32'hA1A1A1A1, 1'b1, 5'd2, 32'hB2B2B2B2, 1'b0, 1, 32'hFFFFFFFD, 16'd6};
        vecs[10] = '{1'b1, 5'd31, 32'h80000000, 1'b0, 5'd0, 32'h0, 1'b0, 1, 32'h7FFFFFFF, 16'd7};
        vecs[11] = '{1'b1, 5'd9, 32'hC0C0C0C0, 1'b1, 5'd9, 32'hC1C1C1C1, 1'b0, 2, 32'hFFFFFDFF, 16'd8};
        vecs[12] = '{1'b1, 5'd9, 32'hC0C0C0C0, 1'b1, 5'd9, 32'hC1C1C1C1, 1'b0, 1, 32'hFFFFFDFF, 16'd9};
        vecs[13] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hD1D1D1D1, 1'b0, 2, 32'hFFFFFDFF, 16'd10};
        vecs[14] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 3, 32'hFFFFFFFF, 16'd10};

        drive(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        #3;
        check("rst writeEnable", 64'(bus.writeEnable), 64'hFFFFFFFF);
        check("rst writeData", 64'(bus.writeData), 64'd0);
        check("rst fwd_valid", 64'(bus.fwd_valid), 64'd0);
        check("rst writeCount", 64'(bus.writeCount), 64'd0);
        check("rst req0_ready", 64'(bus.req0_ready), 64'd0);
        check("rst req1_ready", 64'(bus.req1_ready), 64'd0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) apply(vecs[i], i);

        // Reset asserted between clock edges while a write to r7 is in the stage
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd7, 32'h77777777, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        check("mid writeEnable", 64'(bus.writeEnable), 64'hFFFFFF7F);
        check("mid writeCount", 64'(bus.writeCount), 64'd11);
        drive(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        #1 rst = 1'b0;
        #1;
        check("abort writeEnable", 64'(bus.writeEnable), 64'hFFFFFFFF);
        check("abort writeCount", 64'(bus.writeCount), 64'd0);
        check("abort writeData", 64'(bus.writeData), 64'd0);
        check("abort fwd_valid", 64'(bus.fwd_valid), 64'd0);
        check("abort req0_ready", 64'(bus.req0_ready), 64'd0);
        check("abort req1_ready", 64'(bus.req1_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("first req0_ready", 64'(bus.req0_ready), 64'd1);
        check("first req1_ready", 64'(bus.req1_ready), 64'd0);
        @(posedge clk);
        #1;
        check("first writeEnable", 64'(bus.writeEnable), 64'hFFFFFFFD);
        check("first writeData", 64'(bus.writeData), 64'h11);
        check("first writeCount", 64'(bus.writeCount), 64'd1);

        // Counter wrap: 65535 writes from reset reach all ones, one more returns to zero
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
        #1;
        check("wrap reset", 64'(bus.writeCount), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        check("wrap all_ones", 64'(bus.writeCount), 64'hFFFF);
        @(posedge clk);
        #1;
        check("wrap zero", 64'(bus.writeCount), 64'd0);
        check("wrap writeEnable", 64'(bus.writeEnable), 64'hFFFFFFF7);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        check("idle writeEnable", 64'(bus.writeEnable), 64'hFFFFFFFF);
        check("idle writeData", 64'(bus.writeData), 64'h33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter ZERO_PROTECT, default 1, meaning writes to address 0 are accepted but never enabled.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the committed-write counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  active-high; while high, no new request is granted.
REQ-006 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-007 req0_addr  input  5  requester 0 destination register index.
REQ-008 req0_data  input  32  requester 0 write data.
REQ-009 req0_ready  output  1  requester 0 is granted this cycle.
REQ-010 req1_valid, req1_addr[4:0], req1_data[31:0] (inputs) and req1_ready (output) SHALL mirror REQ-006..009 for requester 1 (load writeback).
REQ-011 writeEnable  output  32  per-register write enable, active low, bit i drives register i.
REQ-012 writeData  output  32  data broadcast to all 32 registers.
REQ-013 fwd_valid, fwd_addr[4:0], fwd_data[31:0]  outputs  copy of the in-flight write stage, for forwarding.
REQ-014 writeCount  output  CNT_W  number of committed (enabled) writes since reset.

Function
REQ-015 SHALL transfer a request when reqX_valid and reqX_ready are both high at a rising clk edge.
REQ-016 reqX_ready SHALL be combinational: low when stall=1; otherwise high for at most one requester per cycle.
REQ-017 SHALL grant a lone valid requester immediately; ready SHALL NOT depend on the other requester's data or address.
REQ-018 When both requesters are valid, SHALL grant the requester indicated by 1-bit priority pointer prio (0 -> req0, 1 -> req1).
REQ-019 After every transfer, prio SHALL point to the non-granted requester; with no transfer, prio SHALL hold.
REQ-020 Ready MAY be asserted while valid is low; a requester SHALL NOT lose its turn because the other is idle.
REQ-021 A transfer SHALL load stage registers wr_valid=1, wr_addr, wr_data; with no transfer, wr_valid SHALL load 0.
REQ-022 Latency SHALL be one cycle: the cycle after the transfer, writeEnable[wr_addr]=0 and all other bits are 1.
REQ-023 When no write is in flight, writeEnable SHALL be all ones.
REQ-024 The register then captures data on the following edge.
REQ-025 writeData SHALL equal wr_data whenever wr_valid=1, and SHALL hold its last value otherwise.
REQ-026 When ZERO_PROTECT=1 and wr_addr=0, all writeEnable bits SHALL stay 1 and writeCount SHALL NOT increment.
REQ-027 Throughput SHALL be one write per cycle; back-to-back writes to the same address SHALL both commit in order.
REQ-028 Both requesters targeting the same address in one cycle: the prio winner commits first, the loser commits on a later transfer (later write wins).
REQ-029 stall asserted SHALL NOT cancel a write already in the stage register; that write completes in its cycle.
REQ-030 fwd_valid SHALL equal wr_valid and not (ZERO_PROTECT and wr_addr=0); fwd_addr=wr_addr and fwd_data=wr_data.
REQ-031 writeCount SHALL increment by 1 per enabled write and wrap from all-ones to 0.

Reset
REQ-032 While rst=0, asynchronously: writeEnable=32'hFFFFFFFF, writeData=0, wr_valid=0, fwd_valid=0, prio=0, writeCount=0.
REQ-033 While rst=0, req0_ready and req1_ready SHALL be 0.
REQ-034 Reset asserted mid-write SHALL abort the in-flight write, leaving all enables high.
REQ-035 First grant after reset release SHALL go to req0 if both requesters are valid.

Verification
REQ-036 Reset, then req0 valid addr=5 data=0xDEADBEEF -> next cycle writeEnable=0xFFFFFFDF, writeData=0xDEADBEEF, writeCount=1.
REQ-037 Both requesters valid for 4 cycles (addr 1 and 2) -> grants alternate req0,req1,req0,req1; writeCount=4.
REQ-038 req1 valid addr=0 data=0x1234, ZERO_PROTECT=1 -> req1_ready=1, writeEnable stays 0xFFFFFFFF, fwd_valid=0, writeCount unchanged.
REQ-039 stall=1 with both valid for 3 cycles -> both ready=0, enables all 1 after the in-flight write; stall=0 -> req0 granted.
REQ-040 rst pulsed low while wr_valid=1 (addr=7) -> writeEnable=0xFFFFFFFF immediately, writeCount=0, prio=0.
REQ-041 writeCount preset to 0xFFFF by 65535 writes, one more write -> writeCount=0.
